// File: rtl/branch_pkg.sv
// Shared definitions for the EX-stage branch resolver: widths, funct3 codes, FSM states.
// No logic; no latency or backpressure of its own.
// Imported by branch_resolve and br_cond.
package branch_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_ILL0 = 3'b010;
  localparam logic [2:0] F3_ILL1 = 3'b011;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic {
    RUN    = 1'b0,
    SHADOW = 1'b1
  } state_t;

endpackage

// File: rtl/br_cond.sv
// Branch condition decode: funct3 plus comparator flags -> condition met / illegal code.
// Latency: purely combinational, zero cycles.
// Backpressure: none; evaluated every cycle.
module br_cond
  import branch_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       less,
  input  logic       equal,
  output logic       cond,
  output logic       illegal
);

  always_comb begin
    cond    = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:           cond    = equal;
      F3_BNE:           cond    = !equal;
      F3_BLT, F3_BLTU:  cond    = less;
      F3_BGE, F3_BGEU:  cond    = !less;
      F3_ILL0, F3_ILL1: illegal = 1'b1;
      default:          cond    = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// EX-stage branch/jump resolver: redirect + flush, fetch PC register, fault pulses, taken counter.
// Latency: redirect/flush combinational in cycle N, o_pc holds the target in N+1.
// Backpressure: i_stall holds the fetch PC; a redirect always overrides the stall.
module branch_resolve
  import branch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  input  logic            i_is_branch,
  input  logic            i_is_jal,
  input  logic            i_is_jalr,
  input  logic [2:0]      i_funct3,
  input  logic            i_br_less,
  input  logic            i_br_equal,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_imm,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic            i_stall,
  output logic            o_br_unsigned,
  output logic [XLEN-1:0] o_pc,
  output logic            o_flush,
  output logic            o_misalign,
  output logic            o_br_illegal,
  output logic [15:0]     o_taken_cnt
);

  state_t          state_q, state_nxt;
  logic [15:0]     taken_cnt_q;
  logic            cond, illegal;
  logic            is_br, is_jal, is_jalr;
  logic            elig, taken, misalign, redirect;
  logic [XLEN-1:0] base, sum, target, pc_nxt;

  br_cond u_br_cond (
    .funct3  (i_funct3),
    .less    (i_br_less),
    .equal   (i_br_equal),
    .cond    (cond),
    .illegal (illegal)
  );

  // Anything other than exactly one class bit is treated as a non-control instruction.
  assign is_br   =  i_is_branch && !i_is_jal && !i_is_jalr;
  assign is_jal  = !i_is_branch &&  i_is_jal && !i_is_jalr;
  assign is_jalr = !i_is_branch && !i_is_jal &&  i_is_jalr;

  assign elig     = i_valid && (state_q == RUN);
  assign taken    = elig && (is_jal || is_jalr || (is_br && cond));
  assign base     = is_jalr ? i_rs1_data : i_pc;
  assign sum      = base + i_imm;
  assign target   = is_jalr ? {sum[XLEN-1:1], 1'b0} : sum;
  assign misalign = taken && target[1];
  assign redirect = taken && !misalign;

  assign o_br_unsigned = i_funct3[1];
  assign o_flush       = redirect && i_rst_n;
  assign o_taken_cnt   = taken_cnt_q;

  always_comb begin
    pc_nxt = o_pc + 32'd4;
    if (redirect)     pc_nxt = target;
    else if (i_stall) pc_nxt = o_pc;
  end

  // SHADOW covers the cycle(s) where the instruction behind a redirect is still in EX.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      RUN:     if (redirect) state_nxt = SHADOW;
      SHADOW:  if (!i_stall) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_pc         <= RESET_PC;
      state_q      <= RUN;
      taken_cnt_q  <= 16'h0000;
      o_misalign   <= 1'b0;
      o_br_illegal <= 1'b0;
    end else begin
      o_pc         <= pc_nxt;
      state_q      <= state_nxt;
      o_misalign   <= misalign;
      o_br_illegal <= elig && is_br && illegal;
      if (redirect && is_br && taken_cnt_q != 16'hFFFF)
        taken_cnt_q <= taken_cnt_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: one task per scenario, inline comparisons.
module tb_branch_resolve;

  localparam logic [31:0] RST_PC = 32'h0000_1000;

  logic        i_clk = 1'b0;
  logic        i_rst_n, i_valid, i_is_branch, i_is_jal, i_is_jalr;
  logic [2:0]  i_funct3;
  logic        i_br_less, i_br_equal, i_stall;
  logic [31:0] i_pc, i_imm, i_rs1_data;
  logic        o_br_unsigned, o_flush, o_misalign, o_br_illegal;
  logic [31:0] o_pc;
  logic [15:0] o_taken_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  branch_resolve #(.RESET_PC(RST_PC)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_valid       (i_valid),
    .i_is_branch   (i_is_branch),
    .i_is_jal      (i_is_jal),
    .i_is_jalr     (i_is_jalr),
    .i_funct3      (i_funct3),
    .i_br_less     (i_br_less),
    .i_br_equal    (i_br_equal),
    .i_pc          (i_pc),
    .i_imm         (i_imm),
    .i_rs1_data    (i_rs1_data),
    .i_stall       (i_stall),
    .o_br_unsigned (o_br_unsigned),
    .o_pc          (o_pc),
    .o_flush       (o_flush),
    .o_misalign    (o_misalign),
    .o_br_illegal  (o_br_illegal),
    .o_taken_cnt   (o_taken_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_valid = 0; i_is_branch = 0; i_is_jal = 0; i_is_jalr = 0;
    i_funct3 = 3'b000; i_br_less = 0; i_br_equal = 0; i_stall = 0;
    i_pc = 0; i_imm = 0; i_rs1_data = 0;
  endtask

  task automatic drive(input logic br, input logic jal, input logic jalr, input logic [2:0] f3,
                       input logic lt, input logic eq, input logic [31:0] pc,
                       input logic [31:0] imm, input logic [31:0] rs1);
    i_valid = 1; i_is_branch = br; i_is_jal = jal; i_is_jalr = jalr;
    i_funct3 = f3; i_br_less = lt; i_br_equal = eq;
    i_pc = pc; i_imm = imm; i_rs1_data = rs1;
    #1;
  endtask

  task automatic test_reset();
    idle();
    i_rst_n = 0;
    drive(1, 0, 0, 3'b000, 0, 1, 32'h100, 32'h20, 0);
    total_cnt++; if (o_flush !== 1'b0) $display("FAIL reset_flush: got %0b want 0", o_flush); else pass_cnt++;
    tick();
    total_cnt++; if (o_pc !== RST_PC) $display("FAIL reset_pc: got %h want %h", o_pc, RST_PC); else pass_cnt++;
    total_cnt++; if (o_taken_cnt !== 16'h0) $display("FAIL reset_cnt: got %h want 0", o_taken_cnt); else pass_cnt++;
    total_cnt++; if (o_misalign !== 1'b0 || o_br_illegal !== 1'b0)
      $display("FAIL reset_pulses: got mis=%0b ill=%0b want 0 0", o_misalign, o_br_illegal); else pass_cnt++;
    idle();
    i_rst_n = 1;
    tick();
    total_cnt++; if (o_pc !== 32'h1004) $display("FAIL reset_release_pc: got %h want 00001004", o_pc); else pass_cnt++;
  endtask

  task automatic test_not_taken_beq();
    drive(1, 0, 0, 3'b000, 0, 0, 32'h100, 32'h20, 0);
    total_cnt++; if (o_flush !== 1'b0) $display("FAIL beq_nt_flush: got %0b want 0", o_flush); else pass_cnt++;
    tick();
    total_cnt++; if (o_pc !== 32'h1008) $display("FAIL beq_nt_pc: got %h want 00001008", o_pc); else pass_cnt++;
    total_cnt++; if (o_taken_cnt !== 16'd0) $display("FAIL beq_nt_cnt: got %h want 0", o_taken_cnt); else pass_cnt++;
  endtask

  task automatic test_taken_bltu();
    drive(1, 0, 0, 3'b110, 1, 0, 32'h100, 32'hFFFF_FFF8, 0);
    total_cnt++; if (o_br_unsigned !== 1'b1) $display("FAIL bltu_unsigned: got %0b want 1", o_br_unsigned); else pass_cnt++;
    total_cnt++; if (o_flush !== 1'b1) $display("FAIL bltu_flush: got %0b want 1", o_flush); else pass_cnt++;
    tick();
    total_cnt++; if (o_pc !== 32'hF8) $display("FAIL bltu_pc: got %h want 000000f8", o_pc); else pass_cnt++;
    total_cnt++; if (o_taken_cnt !== 16'd1) $display("FAIL bltu_cnt: got %h want 1", o_taken_cnt); else pass_cnt++;
    // shadow cycle: a live taken BEQ must be ignored
    drive(1, 0, 0, 3'b000, 0, 1, 32'h200, 32'h40, 0);
    total_cnt++; if (o_flush !== 1'b0) $display("FAIL shadow_flush: got %0b want 0", o_flush); else pass_cnt++;
    tick();
    total_cnt++; if (o_pc !== 32'hFC) $display("FAIL shadow_pc: got %h want 000000fc", o_pc); else pass_cnt++;
    total_cnt++; if (o_taken_cnt !== 16'd1) $display("FAIL shadow_cnt: got %h want 1", o_taken_cnt); else pass_cnt++;
    // back in RUN, the same branch now resolves
    drive(1, 0, 0, 3'b000, 0, 1, 32'h200, 32'h40, 0);
    total_cnt++; if (o_flush !== 1'b1) $display("FAIL run_again_flush: got %0b want 1", o_flush); else pass_cnt++;
    tick();
    total_cnt++; if (o_pc !== 32'h240) $display("FAIL run_again_pc: got %h want 00000240", o_pc); else pass_cnt++;
    total_cnt++; if (o_taken_cnt !== 16'd2) $display("FAIL run_again_cnt: got %h want 2", o_taken_cnt); else pass_cnt++;
    idle();
    tick();
  endtask

  task automatic test_jalr();
    drive(0, 0, 1, 3'b000, 0, 0, 32'h500, 32'h4, 32'h2001);
    total_cnt++; if (o_flush !== 1'b1) $display("FAIL jalr_flush: got %0b want 1", o_flush); else pass_cnt++;
    tick();
    total_cnt++; if (o_pc !== 32'h2004) $display("FAIL jalr_pc: got %h want 00002004", o_pc); else pass_cnt++;
    total_cnt++; if (o_taken_cnt !== 16'd2) $display("FAIL jalr_cnt: got %h want 2", o_taken_cnt); else pass_cnt++;
    idle();
    tick();
  endtask

  task automatic test_misalign_jal();
    drive(0, 1, 0, 3'b000, 0, 0, 32'h100, 32'h6, 0);
    total_cnt++; if (o_flush !== 1'b0) $display("FAIL mis_flush: got %0b want 0", o_flush); else pass_cnt++;
    tick();
    total_cnt++; if (o_pc !== 32'h200C) $display("FAIL mis_pc: got %h want 0000200c", o_pc); else pass_cnt++;
    total_cnt++; if (o_misalign !== 1'b1) $display("FAIL mis_pulse: got %0b want 1", o_misalign); else pass_cnt++;
    idle();
    tick();
    total_cnt++; if (o_misalign !== 1'b0) $display("FAIL mis_pulse_end: got %0b want 0", o_misalign); else pass_cnt++;
    total_cnt++; if (o_pc !== 32'h2010) $display("FAIL mis_pc2: got %h want 00002010", o_pc); else pass_cnt++;
  endtask

  task automatic test_stall_redirect();
    // FSM left in RUN after the misaligned jal, so this must redirect despite the stall
    i_stall = 1;
    drive(1, 0, 0, 3'b000, 0, 1, 32'h300, 32'h10, 0);
    total_cnt++; if (o_flush !== 1'b1) $display("FAIL stall_flush: got %0b want 1", o_flush); else pass_cnt++;
    tick();
    total_cnt++; if (o_pc !== 32'h310) $display("FAIL stall_pc: got %h want 00000310", o_pc); else pass_cnt++;
    total_cnt++; if (o_taken_cnt !== 16'd3) $display("FAIL stall_cnt: got %h want 3", o_taken_cnt); else pass_cnt++;
    for (int k = 0; k < 2; k++) begin
      drive(1, 0, 0, 3'b000, 0, 1, 32'h400, 32'h10, 0);
      total_cnt++; if (o_flush !== 1'b0) $display("FAIL stall_shadow_flush%0d: got %0b want 0", k, o_flush); else pass_cnt++;
      tick();
      total_cnt++; if (o_pc !== 32'h310) $display("FAIL stall_hold_pc%0d: got %h want 00000310", k, o_pc); else pass_cnt++;
    end
    idle();
    tick();
    total_cnt++; if (o_pc !== 32'h314) $display("FAIL unstall_pc: got %h want 00000314", o_pc); else pass_cnt++;
    drive(1, 0, 0, 3'b010, 1, 1, 32'h600, 32'h10, 0);
    total_cnt++; if (o_flush !== 1'b0) $display("FAIL ill_flush: got %0b want 0", o_flush); else pass_cnt++;
    tick();
    total_cnt++; if (o_br_illegal !== 1'b1) $display("FAIL ill_pulse: got %0b want 1", o_br_illegal); else pass_cnt++;
    total_cnt++; if (o_pc !== 32'h318) $display("FAIL ill_pc: got %h want 00000318", o_pc); else pass_cnt++;
    idle();
    tick();
    total_cnt++; if (o_br_illegal !== 1'b0) $display("FAIL ill_pulse_end: got %0b want 0", o_br_illegal); else pass_cnt++;
  endtask

  task automatic test_multi_hot();
    drive(1, 1, 0, 3'b000, 0, 1, 32'h700, 32'h10, 0);
    total_cnt++; if (o_flush !== 1'b0) $display("FAIL multi_flush: got %0b want 0", o_flush); else pass_cnt++;
    tick();
    total_cnt++; if (o_pc !== 32'h320) $display("FAIL multi_pc: got %h want 00000320", o_pc); else pass_cnt++;
    total_cnt++; if (o_taken_cnt !== 16'd3) $display("FAIL multi_cnt: got %h want 3", o_taken_cnt); else pass_cnt++;
    idle();
  endtask

  task automatic test_saturation();
    dut.taken_cnt_q = 16'hFFFF;
    drive(1, 0, 0, 3'b001, 0, 0, 32'h800, 32'h8, 0);
    total_cnt++; if (o_flush !== 1'b1) $display("FAIL sat_flush: got %0b want 1", o_flush); else pass_cnt++;
    tick();
    total_cnt++; if (o_taken_cnt !== 16'hFFFF) $display("FAIL sat_cnt: got %h want ffff", o_taken_cnt); else pass_cnt++;
    total_cnt++; if (o_pc !== 32'h808) $display("FAIL sat_pc: got %h want 00000808", o_pc); else pass_cnt++;
    idle();
    tick();
  endtask

  task automatic test_reset_priority();
    i_rst_n = 0;
    drive(0, 1, 0, 3'b000, 0, 0, 32'h900, 32'h40, 0);
    total_cnt++; if (o_flush !== 1'b0) $display("FAIL rstpri_flush: got %0b want 0", o_flush); else pass_cnt++;
    tick();
    total_cnt++; if (o_pc !== RST_PC) $display("FAIL rstpri_pc: got %h want %h", o_pc, RST_PC); else pass_cnt++;
    total_cnt++; if (o_taken_cnt !== 16'd0) $display("FAIL rstpri_cnt: got %h want 0", o_taken_cnt); else pass_cnt++;
    idle();
    i_rst_n = 1;
    tick();
  endtask

  initial begin
    idle();
    i_rst_n = 0;
    test_reset();
    test_not_taken_beq();
    test_taken_bltu();
    test_jalr();
    test_misalign_jal();
    test_stall_redirect();
    test_multi_hot();
    test_saturation();
    test_reset_priority();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
